// File: rtl/aes_inv_key_expansion.sv
// ============================================================================
// Module   : aes_inv_key_expansion
// Purpose  : AES-128 inverse key schedule; regenerates round keys 10..0 from
//            the round-10 key, one round key per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module aes_inv_key_expansion (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start_in,
    input  logic [31:0] key0_in,
    input  logic [31:0] key1_in,
    input  logic [31:0] key2_in,
    input  logic [31:0] key3_in,
    output logic [31:0] key0_out,
    output logic [31:0] key1_out,
    output logic [31:0] key2_out,
    output logic [31:0] key3_out,
    output logic [3:0]  round_out,
    output logic        valid_out,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ROUND10   = 2'd1,
        S_ROUND9TO1 = 2'd2,
        S_ROUND0    = 2'd3
    } state_t;

    // Forward S-box; row 0 sits in the MSBs so entry b is c_SBOX[b].
    localparam logic [0:255][7:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [31:0] w0_q, w1_q, w2_q, w3_q;
    logic [31:0] w0_d, w1_d, w2_d, w3_d;
    logic [3:0]  round_q, round_d;

    logic [31:0] w_w3n, w_w2n, w_w1n, w_w0n;
    logic [31:0] w_rot, w_sub;

    // Previous-round words 1..3 fall out of XORs; word 0 needs the g() term
    // computed on the recovered word 3.
    assign w_w3n = w3_q ^ w2_q;
    assign w_w2n = w2_q ^ w1_q;
    assign w_w1n = w1_q ^ w0_q;
    assign w_rot = {w_w3n[23:0], w_w3n[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign w_sub[8*gi +: 8] = c_SBOX[w_rot[8*gi +: 8]];
        end
    endgenerate

    assign w_w0n = w0_q ^ w_sub ^ {rcon(round_q), 24'h0};

    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    w0_d    = key0_in;
                    w1_d    = key1_in;
                    w2_d    = key2_in;
                    w3_d    = key3_in;
                    round_d = 4'd10;
                    state_d = S_ROUND10;
                end
            end
            S_ROUND10, S_ROUND9TO1: begin
                w0_d    = w_w0n;
                w1_d    = w_w1n;
                w2_d    = w_w2n;
                w3_d    = w_w3n;
                round_d = round_q - 4'd1;
                if (state_q == S_ROUND10) begin
                    state_d = S_ROUND9TO1;
                end else if (round_q == 4'd1) begin
                    state_d = S_ROUND0;
                end
            end
            S_ROUND0: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            w0_q    <= 32'h0;
            w1_q    <= 32'h0;
            w2_q    <= 32'h0;
            w3_q    <= 32'h0;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            round_q <= round_d;
        end
    end

    assign key0_out  = w0_q;
    assign key1_out  = w1_q;
    assign key2_out  = w2_q;
    assign key3_out  = w3_q;
    assign round_out = round_q;
    assign valid_out = (state_q != S_IDLE);
    assign state_out = state_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_key_expansion.sv
// ============================================================================
// Module   : tb_aes_inv_key_expansion
// Purpose  : Directed self-checking bench for the AES-128 inverse key schedule.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_aes_inv_key_expansion;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start_in;
    logic [31:0] key0_in, key1_in, key2_in, key3_in;
    logic [31:0] key0_out, key1_out, key2_out, key3_out;
    logic [3:0]  round_out;
    logic        valid_out;
    logic [1:0]  state_out;

    aes_inv_key_expansion dut (
        .CLK       (CLK),
        .RST       (RST),
        .start_in  (start_in),
        .key0_in   (key0_in),
        .key1_in   (key1_in),
        .key2_in   (key2_in),
        .key3_in   (key3_in),
        .key0_out  (key0_out),
        .key1_out  (key1_out),
        .key2_out  (key2_out),
        .key3_out  (key3_out),
        .round_out (round_out),
        .valid_out (valid_out),
        .state_out (state_out)
    );

    always #5 CLK = ~CLK;

    localparam logic [127:0] c_KF_R10 = 128'h28FDDEF86DA4244ACCC0A4FE3B316F26;
    localparam logic [127:0] c_KF_R9  = 128'hBFE2BF904559FAB2A16480B4F7F1CBD8;
    localparam logic [127:0] c_KF_R1  = 128'hE232FCF191129188B159E4E6D679A293;
    localparam logic [127:0] c_KF_R0  = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] c_F1_R10 = 128'h13111D7FE3944A17F307A78B4D2B30C5;
    localparam logic [127:0] c_F1_R0  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] c_F2_R10 = 128'hD014F9A8C9EE2589E13F0CC8B6630CA6;
    localparam logic [127:0] c_F2_R9  = 128'hAC7766F319FADC2128D12941575C006E;
    localparam logic [127:0] c_F2_R2  = 128'hF2C295F27A96B9435935807A7359F67F;
    localparam logic [127:0] c_F2_R1  = 128'hA0FAFE1788542CB123A339392A6C7605;
    localparam logic [127:0] c_F2_R0  = 128'h2B7E151628AED2A6ABF7158809CF4F3C;

    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] cap_key   [12];
    logic [3:0]   cap_round [12];
    logic [1:0]   cap_state [12];
    logic         cap_valid [12];

    wire [127:0] w_key_out = {key0_out, key1_out, key2_out, key3_out};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulses start with k10 and samples 12 negedges: index k shows round 10-k,
    // index 11 is the return to idle. Optionally re-pulses start at round 5.
    task automatic run_seq(input logic [127:0] k10, input bit poke_mid);
        @(negedge CLK);
        {key0_in, key1_in, key2_in, key3_in} = k10;
        start_in = 1'b1;
        @(negedge CLK);
        start_in = 1'b0;
        {key0_in, key1_in, key2_in, key3_in} = ~k10;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge CLK);
            cap_key[k]   = w_key_out;
            cap_round[k] = round_out;
            cap_state[k] = state_out;
            cap_valid[k] = valid_out;
            start_in = (poke_mid && k == 5);
        end
        start_in = 1'b0;
    endtask

    initial begin
        RST      = 1'b0;
        start_in = 1'b0;
        {key0_in, key1_in, key2_in, key3_in} = '0;
        repeat (2) @(negedge CLK);
        check("rst_key",   w_key_out, 128'h0);
        check("rst_round", 128'(round_out), 128'd0);
        check("rst_valid", 128'(valid_out), 128'd0);
        check("rst_state", 128'(state_out), 128'd0);
        RST = 1'b1;

        // Known-answer run: round keys of "Thats my Kung Fu"
        run_seq(c_KF_R10, 1'b0);
        check("kf_r10_key",   cap_key[0], c_KF_R10);
        check("kf_r10_state", 128'(cap_state[0]), 128'd1);
        check("kf_r9_key",    cap_key[1], c_KF_R9);
        check("kf_r1_key",    cap_key[9], c_KF_R1);
        check("kf_r1_state",  128'(cap_state[9]), 128'd2);
        check("kf_r0_key",    cap_key[10], c_KF_R0);
        check("kf_r0_state",  128'(cap_state[10]), 128'd3);
        check("kf_idle_state", 128'(cap_state[11]), 128'd0);
        check("kf_idle_valid", 128'(cap_valid[11]), 128'd0);
        check("kf_idle_key",   cap_key[11], c_KF_R0);
        check("kf_idle_round", 128'(cap_round[11]), 128'd0);
        for (int k = 0; k < 11; k++) begin
            check($sformatf("kf_round_k%0d", k), 128'(cap_round[k]), 128'(10 - k));
            check($sformatf("kf_valid_k%0d", k), 128'(cap_valid[k]), 128'd1);
        end

        // FIPS-197 cipher key 000102..0F
        run_seq(c_F1_R10, 1'b0);
        check("f1_r10_key", cap_key[0], c_F1_R10);
        check("f1_r0_key",  cap_key[10], c_F1_R0);
        check("f1_r0_round", 128'(cap_round[10]), 128'd0);

        // Start re-asserted mid-sequence must be ignored
        run_seq(c_KF_R10, 1'b1);
        check("poke_r5_round", 128'(cap_round[5]), 128'd5);
        check("poke_r4_round", 128'(cap_round[6]), 128'd4);
        check("poke_r1_key",   cap_key[9], c_KF_R1);
        check("poke_r0_key",   cap_key[10], c_KF_R0);
        check("poke_r0_state", 128'(cap_state[10]), 128'd3);
        check("poke_idle",     128'(cap_state[11]), 128'd0);

        // Asynchronous reset at round 6, then a clean restart
        @(negedge CLK);
        {key0_in, key1_in, key2_in, key3_in} = c_KF_R10;
        start_in = 1'b1;
        @(negedge CLK);
        start_in = 1'b0;
        repeat (4) @(negedge CLK);
        check("ar_pre_round", 128'(round_out), 128'd6);
        #2 RST = 1'b0;
        #1;
        check("ar_key",   w_key_out, 128'h0);
        check("ar_round", 128'(round_out), 128'd0);
        check("ar_state", 128'(state_out), 128'd0);
        check("ar_valid", 128'(valid_out), 128'd0);
        #1 RST = 1'b1;
        run_seq(c_KF_R10, 1'b0);
        check("ar_r10_key", cap_key[0], c_KF_R10);
        check("ar_r9_key",  cap_key[1], c_KF_R9);
        check("ar_r1_key",  cap_key[9], c_KF_R1);
        check("ar_r0_key",  cap_key[10], c_KF_R0);

        // FIPS-197 key 2B7E15..3C: compare against its forward round keys
        run_seq(c_F2_R10, 1'b0);
        check("f2_r9_key", cap_key[1], c_F2_R9);
        check("f2_r2_key", cap_key[8], c_F2_R2);
        check("f2_r1_key", cap_key[9], c_F2_R1);
        check("f2_r0_key", cap_key[10], c_F2_R0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
